mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 46 ++++
 rtl/mem_stage_if.sv | 38 +++
 rtl/mem_align.sv | 49 ++++
 rtl/mem_stage.sv | 157 +++++++++++++++
 tb/tb_mem_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: memory-op and ALU codes, FSM states,
// and small op-decode helpers.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LW   = 3'd1,
    MEM_LB   = 3'd2,
    MEM_LBU  = 3'd3,
    MEM_SW   = 3'd4,
    MEM_SB   = 3'd5
  } mem_op_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8,
    ALU_LUI = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_store(mem_op_e op);
    return (op == MEM_SW) || (op == MEM_SB);
  endfunction

  function automatic logic is_mem(mem_op_e op);
    return (op == MEM_LW) || (op == MEM_LB) || (op == MEM_LBU) || is_store(op);
  endfunction

  // Only word accesses can be misaligned; byte accesses are legal at any address.
  function automatic logic addr_misaligned(mem_op_e op, logic [1:0] lo);
    return ((op == MEM_LW) || (op == MEM_SW)) && (lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute handshake, data bus, writeback and exception signals of the memory stage.
interface mem_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [2:0]  ex_mem_op;
  logic [4:0]  ex_wreg;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  logic        exc_adel;
  logic        exc_ades;
  logic        exc_buserr;
  logic [31:0] exc_badvaddr;

  modport master (
    input  ex_valid, ex_addr, ex_wdata, ex_mem_op, ex_wreg, bus_ack, bus_rdata,
    output ex_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
           wb_valid, wb_reg, wb_data, exc_adel, exc_ades, exc_buserr, exc_badvaddr
  );

  modport slave (
    output ex_valid, ex_addr, ex_wdata, ex_mem_op, ex_wreg, bus_ack, bus_rdata,
    input  ex_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
           wb_valid, wb_reg, wb_data, exc_adel, exc_ades, exc_buserr, exc_badvaddr
  );
endinterface

// File: rtl/mem_align.sv
// Little-endian byte-lane logic: store lane enables and replicated data,
// and load byte selection with sign/zero extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  mem_op_e     op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic [7:0] rd_byte;

  assign rd_byte = rdata_i[{lane_i, 3'b000} +: 8];

  always_comb begin
    be_o      = 4'b0000;
    st_data_o = 32'h0;
    ld_data_o = 32'h0;
    case (op_i)
      MEM_LW: begin
        be_o      = 4'b1111;
        ld_data_o = rdata_i;
      end
      MEM_LB: begin
        be_o      = 4'b0001 << lane_i;
        ld_data_o = {{24{rd_byte[7]}}, rd_byte};
      end
      MEM_LBU: begin
        be_o      = 4'b0001 << lane_i;
        ld_data_o = {24'h0, rd_byte};
      end
      MEM_SW: begin
        be_o      = 4'b1111;
        st_data_o = wdata_i;
      end
      // The byte is replicated on every lane; be_o picks the one the slave writes.
      MEM_SB: begin
        be_o      = 4'b0001 << lane_i;
        st_data_o = {4{wdata_i[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: accepts one op from execute, runs a single bus
// transaction for loads/stores (with ack timeout) and produces writeback or exceptions.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  mem_stage_if.master m
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e           state_q, state_d;
  mem_op_e          op_q, op_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_reg_q, wb_reg_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             adel_q, adel_d;
  logic             ades_q, ades_d;
  logic             buserr_q, buserr_d;
  logic [31:0]      badv_q, badv_d;

  mem_op_e     ex_op;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_ld;
  logic        in_bus;

  assign ex_op  = mem_op_e'(m.ex_mem_op);
  assign in_bus = (state_q == BUS);

  mem_align u_align (
    .op_i      (op_q),
    .lane_i    (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (rdata_q),
    .be_o      (align_be),
    .st_data_o (align_wdata),
    .ld_data_o (align_ld)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wreg_d     = wreg_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;
    adel_d     = 1'b0;
    ades_d     = 1'b0;
    buserr_d   = 1'b0;
    badv_d     = badv_q;
    case (state_q)
      IDLE: begin
        if (m.ex_valid) begin
          if (addr_misaligned(ex_op, m.ex_addr[1:0])) begin
            badv_d = m.ex_addr;
            if (ex_op == MEM_LW) adel_d = 1'b1;
            else                 ades_d = 1'b1;
          end else if (is_mem(ex_op)) begin
            op_d    = ex_op;
            addr_d  = m.ex_addr;
            wdata_d = m.ex_wdata;
            wreg_d  = is_store(ex_op) ? 5'd0 : m.ex_wreg;
            cnt_d   = '0;
            state_d = BUS;
          end else begin
            wb_valid_d = 1'b1;
            wb_reg_d   = m.ex_wreg;
            wb_data_d  = m.ex_addr;
          end
        end
      end
      // Ack wins over timeout when both land on the same cycle.
      BUS: begin
        if (m.bus_ack) begin
          rdata_d = m.bus_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          buserr_d = 1'b1;
          badv_d   = addr_q;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        wb_valid_d = 1'b1;
        wb_reg_d   = wreg_q;
        wb_data_d  = is_store(op_q) ? 32'h0 : align_ld;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= MEM_NONE;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      wreg_q     <= 5'd0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= 5'd0;
      wb_data_q  <= 32'h0;
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
      buserr_q   <= 1'b0;
      badv_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      wreg_q     <= wreg_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      adel_q     <= adel_d;
      ades_q     <= ades_d;
      buserr_q   <= buserr_d;
      badv_q     <= badv_d;
    end
  end

  // Bus outputs decode straight from state so reset drops bus_req without a clock.
  assign m.ex_ready     = (state_q == IDLE);
  assign m.bus_req      = in_bus;
  assign m.bus_we       = in_bus & is_store(op_q);
  assign m.bus_addr     = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
  assign m.bus_be       = in_bus ? align_be : 4'b0000;
  assign m.bus_wdata    = in_bus ? align_wdata : 32'h0;
  assign m.wb_valid     = wb_valid_q;
  assign m.wb_reg       = wb_reg_q;
  assign m.wb_data      = wb_data_q;
  assign m.exc_adel     = adel_q;
  assign m.exc_ades     = ades_q;
  assign m.exc_buserr   = buserr_q;
  assign m.exc_badvaddr = badv_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized ops against an arithmetic model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mem_stage_if ifc ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m     (ifc.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
    logic        stable;
    logic        req_after;
    logic        wb_early;
    logic        wb_v;
    logic [4:0]  wb_r;
    logic [31:0] wb_d;
    logic        wb_late;
  } obs_t;

  // Reference model: plain arithmetic on the little-endian byte lanes.
  function automatic logic [3:0] m_be(logic [2:0] op, logic [31:0] addr);
    if (op == MEM_LW || op == MEM_SW) return 4'd15;
    return 4'(1 << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] op, logic [31:0] wd);
    if (op == MEM_SW) return wd;
    if (op == MEM_SB) return (wd % 256) * 32'h0101_0101;
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] op, logic [31:0] addr, logic [31:0] rd);
    logic [31:0] b;
    b = (rd >> ((addr % 4) * 8)) % 256;
    if (op == MEM_LW) return rd;
    if (op == MEM_LB && b >= 128) return b + 32'hFFFF_FF00;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [2:0] op, logic [31:0] addr, logic [31:0] wd, logic [4:0] wreg);
    ifc.ex_valid  = 1'b1;
    ifc.ex_mem_op = op;
    ifc.ex_addr   = addr;
    ifc.ex_wdata  = wd;
    ifc.ex_wreg   = wreg;
    step();
    ifc.ex_valid  = 1'b0;
  endtask

  // Drives one bus transaction (ex_* kept busy meanwhile) and records what the DUT showed.
  task automatic run_bus(logic [2:0] op, logic [31:0] addr, logic [31:0] wd, logic [4:0] wreg,
                         logic [31:0] rd, int delay, output obs_t o);
    issue(op, addr, wd, wreg);
    o.req = ifc.bus_req; o.addr = ifc.bus_addr; o.be = ifc.bus_be;
    o.we = ifc.bus_we; o.wd = ifc.bus_wdata; o.stable = 1'b1;
    ifc.ex_valid = 1'b1; ifc.ex_mem_op = MEM_NONE; ifc.ex_addr = $urandom; ifc.ex_wreg = 5'd31;
    for (int k = 0; k < delay; k++) begin
      step();
      if (ifc.bus_req !== 1'b1 || ifc.bus_addr !== o.addr || ifc.bus_be !== o.be ||
          ifc.bus_we !== o.we || ifc.bus_wdata !== o.wd) o.stable = 1'b0;
    end
    ifc.bus_ack = 1'b1; ifc.bus_rdata = rd;
    step();
    ifc.bus_ack = 1'b0; ifc.bus_rdata = $urandom; ifc.ex_valid = 1'b0;
    o.req_after = ifc.bus_req; o.wb_early = ifc.wb_valid;
    step();
    o.wb_v = ifc.wb_valid; o.wb_r = ifc.wb_reg; o.wb_d = ifc.wb_data;
    step();
    o.wb_late = ifc.wb_valid;
  endtask

  task automatic test_reset();
    ifc.ex_valid = 1'b0; ifc.ex_mem_op = MEM_NONE; ifc.ex_addr = '0; ifc.ex_wdata = '0;
    ifc.ex_wreg = '0; ifc.bus_ack = 1'b0; ifc.bus_rdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ifc.bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req got=%b exp=0", ifc.bus_req); end
    checks++; if (ifc.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got=%b exp=0", ifc.wb_valid); end
    checks++; if ({ifc.exc_adel, ifc.exc_ades, ifc.exc_buserr} !== 3'b000) begin errors++; $display("FAIL rst_exc got=%b exp=000", {ifc.exc_adel, ifc.exc_ades, ifc.exc_buserr}); end
    checks++; if ({ifc.wb_reg, ifc.wb_data, ifc.exc_badvaddr} !== 69'h0) begin errors++; $display("FAIL rst_regs got=%h exp=0", {ifc.wb_reg, ifc.wb_data, ifc.exc_badvaddr}); end
    rst_n = 1'b1;
    step();
    checks++; if (ifc.ex_ready !== 1'b1) begin errors++; $display("FAIL rst_ex_ready got=%b exp=1", ifc.ex_ready); end
  endtask

  task automatic test_none();
    issue(MEM_NONE, 32'h0000_1234, 32'hDEAD_BEEF, 5'd5);
    checks++; if (ifc.wb_valid !== 1'b1) begin errors++; $display("FAIL none_wb_valid got=%b exp=1", ifc.wb_valid); end
    checks++; if (ifc.wb_reg !== 5'd5) begin errors++; $display("FAIL none_wb_reg got=%0d exp=5", ifc.wb_reg); end
    checks++; if (ifc.wb_data !== 32'h0000_1234) begin errors++; $display("FAIL none_wb_data got=%h exp=00001234", ifc.wb_data); end
    checks++; if (ifc.bus_req !== 1'b0 || ifc.ex_ready !== 1'b1) begin errors++; $display("FAIL none_state got req=%b rdy=%b exp req=0 rdy=1", ifc.bus_req, ifc.ex_ready); end
    step();
    checks++; if (ifc.wb_valid !== 1'b0) begin errors++; $display("FAIL none_wb_pulse got=%b exp=0", ifc.wb_valid); end
  endtask

  task automatic test_byte_load();
    obs_t o;
    run_bus(MEM_LB, 32'h0000_0103, 32'h0, 5'd7, 32'h80FF_0000, 3, o);
    checks++; if (o.req !== 1'b1 || o.addr !== 32'h0000_0100) begin errors++; $display("FAIL lb_bus got req=%b addr=%h exp req=1 addr=00000100", o.req, o.addr); end
    checks++; if (o.be !== 4'b1000 || o.we !== 1'b0) begin errors++; $display("FAIL lb_be got be=%b we=%b exp be=1000 we=0", o.be, o.we); end
    checks++; if (o.stable !== 1'b1 || o.req_after !== 1'b0) begin errors++; $display("FAIL lb_hold got stable=%b req_after=%b exp 1 0", o.stable, o.req_after); end
    checks++; if (o.wb_early !== 1'b0 || o.wb_v !== 1'b1 || o.wb_late !== 1'b0) begin errors++; $display("FAIL lb_wb_pulse got %b%b%b exp 010", o.wb_early, o.wb_v, o.wb_late); end
    checks++; if (o.wb_r !== 5'd7 || o.wb_d !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got reg=%0d data=%h exp reg=7 data=ffffff80", o.wb_r, o.wb_d); end
    run_bus(MEM_LBU, 32'h0000_0103, 32'h0, 5'd8, 32'h80FF_0000, 3, o);
    checks++; if (o.wb_v !== 1'b1 || o.wb_r !== 5'd8 || o.wb_d !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got v=%b reg=%0d data=%h exp v=1 reg=8 data=00000080", o.wb_v, o.wb_r, o.wb_d); end
  endtask

  task automatic test_byte_store();
    obs_t o;
    run_bus(MEM_SB, 32'h0000_0201, 32'h0000_00AB, 5'd9, 32'h1234_5678, 0, o);
    checks++; if (o.we !== 1'b1 || o.be !== 4'b0010) begin errors++; $display("FAIL sb_lane got we=%b be=%b exp we=1 be=0010", o.we, o.be); end
    checks++; if (o.addr !== 32'h0000_0200 || o.wd !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_data got addr=%h wd=%h exp 00000200 abababab", o.addr, o.wd); end
    checks++; if (o.req_after !== 1'b0 || o.wb_early !== 1'b0 || o.wb_v !== 1'b1) begin errors++; $display("FAIL sb_latency got req_after=%b early=%b wb=%b exp 0 0 1", o.req_after, o.wb_early, o.wb_v); end
    checks++; if (o.wb_r !== 5'd0) begin errors++; $display("FAIL sb_wb_reg got=%0d exp=0", o.wb_r); end
  endtask

  task automatic test_misaligned();
    logic saw_req;
    issue(MEM_LW, 32'h0000_0302, 32'h0, 5'd3);
    saw_req = ifc.bus_req;
    checks++; if (ifc.exc_adel !== 1'b1 || ifc.exc_ades !== 1'b0) begin errors++; $display("FAIL adel_flag got adel=%b ades=%b exp 1 0", ifc.exc_adel, ifc.exc_ades); end
    checks++; if (ifc.exc_badvaddr !== 32'h0000_0302) begin errors++; $display("FAIL adel_badv got=%h exp=00000302", ifc.exc_badvaddr); end
    checks++; if (ifc.wb_valid !== 1'b0 || ifc.ex_ready !== 1'b1) begin errors++; $display("FAIL adel_state got wb=%b rdy=%b exp 0 1", ifc.wb_valid, ifc.ex_ready); end
    step();
    saw_req = saw_req | ifc.bus_req;
    checks++; if (ifc.exc_adel !== 1'b0 || saw_req !== 1'b0) begin errors++; $display("FAIL adel_after got adel=%b req_seen=%b exp 0 0", ifc.exc_adel, saw_req); end
    issue(MEM_SW, 32'h0000_0301, 32'h1111_2222, 5'd0);
    checks++; if (ifc.exc_ades !== 1'b1 || ifc.exc_adel !== 1'b0 || ifc.exc_badvaddr !== 32'h0000_0301) begin errors++; $display("FAIL ades got ades=%b adel=%b badv=%h exp 1 0 00000301", ifc.exc_ades, ifc.exc_adel, ifc.exc_badvaddr); end
    checks++; if (ifc.bus_req !== 1'b0 || ifc.wb_valid !== 1'b0) begin errors++; $display("FAIL ades_state got req=%b wb=%b exp 0 0", ifc.bus_req, ifc.wb_valid); end
    step();
  endtask

  task automatic test_timeout();
    int hi;
    hi = 0;
    issue(MEM_LW, 32'h0000_0440, 32'h0, 5'd4);
    for (int k = 0; k < 6 && ifc.bus_req === 1'b1; k++) begin
      hi++;
      step();
    end
    checks++; if (hi != 4) begin errors++; $display("FAIL to_req_cycles got=%0d exp=4", hi); end
    checks++; if (ifc.exc_buserr !== 1'b1 || ifc.exc_badvaddr !== 32'h0000_0440) begin errors++; $display("FAIL to_buserr got err=%b badv=%h exp 1 00000440", ifc.exc_buserr, ifc.exc_badvaddr); end
    checks++; if (ifc.ex_ready !== 1'b1 || ifc.wb_valid !== 1'b0) begin errors++; $display("FAIL to_state got rdy=%b wb=%b exp 1 0", ifc.ex_ready, ifc.wb_valid); end
    step();
    checks++; if (ifc.exc_buserr !== 1'b0 || ifc.wb_valid !== 1'b0) begin errors++; $display("FAIL to_pulse got err=%b wb=%b exp 0 0", ifc.exc_buserr, ifc.wb_valid); end
  endtask

  task automatic test_reset_in_bus();
    issue(MEM_LW, 32'h0000_0400, 32'h0, 5'd6);
    checks++; if (ifc.bus_req !== 1'b1) begin errors++; $display("FAIL rb_req_before got=%b exp=1", ifc.bus_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ifc.bus_req !== 1'b0) begin errors++; $display("FAIL rb_req_async got=%b exp=0", ifc.bus_req); end
    step();
    rst_n = 1'b1;
    ifc.bus_ack = 1'b1; ifc.bus_rdata = 32'hCAFE_F00D;
    step();
    ifc.bus_ack = 1'b0;
    checks++; if (ifc.wb_valid !== 1'b0 || ifc.bus_req !== 1'b0 || ifc.ex_ready !== 1'b1) begin errors++; $display("FAIL rb_late_ack got wb=%b req=%b rdy=%b exp 0 0 1", ifc.wb_valid, ifc.bus_req, ifc.ex_ready); end
    step();
    checks++; if (ifc.wb_valid !== 1'b0 || {ifc.exc_adel, ifc.exc_ades, ifc.exc_buserr} !== 3'b000) begin errors++; $display("FAIL rb_quiet got wb=%b exc=%b exp 0 000", ifc.wb_valid, {ifc.exc_adel, ifc.exc_ades, ifc.exc_buserr}); end
  endtask

  task automatic test_random();
    obs_t        o;
    logic [2:0]  op;
    logic [31:0] addr, wd, rd, exp_wb;
    logic [4:0]  wreg;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 5));
      addr = $urandom; wd = $urandom; rd = $urandom; wreg = 5'($urandom);
      if ((op == MEM_LW || op == MEM_SW) && $urandom_range(0, 2) != 0) addr = addr & 32'hFFFF_FFFC;
      if ((op == MEM_LW || op == MEM_SW) && (addr % 4) != 0) begin
        issue(op, addr, wd, wreg);
        checks++; if (ifc.exc_adel !== (op == MEM_LW) || ifc.exc_ades !== (op == MEM_SW) || ifc.exc_badvaddr !== addr || ifc.bus_req !== 1'b0 || ifc.wb_valid !== 1'b0) begin
          errors++; $display("FAIL rnd_misalign op=%0d got adel=%b ades=%b badv=%h req=%b wb=%b exp badv=%h", op, ifc.exc_adel, ifc.exc_ades, ifc.exc_badvaddr, ifc.bus_req, ifc.wb_valid, addr);
        end
        step();
      end else if (op == MEM_NONE) begin
        issue(op, addr, wd, wreg);
        checks++; if (ifc.wb_valid !== 1'b1 || ifc.wb_reg !== wreg || ifc.wb_data !== addr) begin
          errors++; $display("FAIL rnd_none got v=%b reg=%0d data=%h exp v=1 reg=%0d data=%h", ifc.wb_valid, ifc.wb_reg, ifc.wb_data, wreg, addr);
        end
      end else begin
        run_bus(op, addr, wd, wreg, rd, $urandom_range(0, 3), o);
        checks++; if (o.req !== 1'b1 || o.addr !== (addr - addr % 4) || o.be !== m_be(op, addr) || o.stable !== 1'b1 || o.req_after !== 1'b0) begin
          errors++; $display("FAIL rnd_bus op=%0d got req=%b addr=%h be=%b stable=%b exp addr=%h be=%b", op, o.req, o.addr, o.be, o.stable, addr - addr % 4, m_be(op, addr));
        end
        checks++; if (o.we !== (op == MEM_SW || op == MEM_SB) || o.wd !== m_wdata(op, wd)) begin
          errors++; $display("FAIL rnd_wdata op=%0d got we=%b wd=%h exp wd=%h", op, o.we, o.wd, m_wdata(op, wd));
        end
        exp_wb = (op == MEM_SW || op == MEM_SB) ? 32'h0 : m_load(op, addr, rd);
        checks++; if (o.wb_early !== 1'b0 || o.wb_v !== 1'b1 || o.wb_late !== 1'b0 || o.wb_d !== exp_wb ||
                      o.wb_r !== ((op == MEM_SW || op == MEM_SB) ? 5'd0 : wreg)) begin
          errors++; $display("FAIL rnd_wb op=%0d addr=%h rd=%h got v=%b%b%b reg=%0d data=%h exp data=%h", op, addr, rd, o.wb_early, o.wb_v, o.wb_late, o.wb_r, o.wb_d, exp_wb);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_none();
    test_byte_load();
    test_byte_store();
    test_misaligned();
    test_timeout();
    test_reset_in_bus();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
